// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the CPU control sequencer: opcode
//               constants, timing-state encoding and instruction-register
//               field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Instruction register layout: {op, X, Y}
  localparam int OP_W      = 3;
  localparam int FLD_W     = 3;
  localparam int IR_W      = OP_W + 2 * FLD_W;
  localparam int IR_OP_LSB = 2 * FLD_W;
  localparam int IR_X_LSB  = FLD_W;
  localparam int IR_Y_LSB  = 0;

  // Opcodes; 100..111 are undefined
  localparam logic [OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;

  // Timing states; T0 is idle
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // Opcodes that need the three-step ALU sequence
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_onehot.sv
`default_nettype none
// ============================================================================
// Module      : dec_onehot
// Description : Binary select to one-hot decoder with enable; output is all
//               zeros when the enable is low.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_onehot #(
  parameter int SEL_W = 3,
  parameter int NREG  = 8
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [NREG-1:0]  onehot
);

  // One comparator per output bit, gated by the enable
  for (genvar i = 0; i < NREG; i++) begin : g_bit
    assign onehot[i] = en && (sel == SEL_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_fsm
// Description : Control sequencer for the structural CPU datapath. Latches an
//               instruction in T0 and steps through up to three further
//               timing states, decoding register-file, bus-source and ALU
//               controls from the registered state and instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic [NREG-1:0]   r_in,
  output logic [NREG-1:0]   r_out,
  output logic              a_in,
  output logic              g_in,
  output logic              g_out,
  output logic              sub,
  output logic              din_out,
  output logic              done,
  output logic              busy,
  output logic              illegal
);

  state_t            r_state;
  logic [IR_W-1:0]   r_ir;

  logic [OP_W-1:0]   w_op;
  logic [SEL_W-1:0]  w_x;
  logic [SEL_W-1:0]  w_y;
  logic              w_rin_en;
  logic              w_rout_en;
  logic [SEL_W-1:0]  w_rout_sel;
  logic              w_unused_din;

  assign w_op = r_ir[IR_OP_LSB +: OP_W];
  assign w_x  = r_ir[IR_X_LSB +: SEL_W];
  assign w_y  = r_ir[IR_Y_LSB +: SEL_W];

  // Only the top IR_W bits of din carry the instruction
  assign w_unused_din = ^din[DATA_W-IR_W-1:0];

  // State sequencing and instruction capture; run is only honoured in T0
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        T0: begin
          if (run) begin
            r_ir    <= din[DATA_W-1 -: IR_W];
            r_state <= T1;
          end
        end
        T1:      r_state <= is_alu_op(w_op) ? T2 : T0;
        T2:      r_state <= T3;
        T3:      r_state <= T0;
        default: r_state <= T0;
      endcase
    end
  end

  // Moore decode of control strobes from state and IR
  always_comb begin
    w_rin_en   = 1'b0;
    w_rout_en  = 1'b0;
    w_rout_sel = w_x;
    a_in       = 1'b0;
    g_in       = 1'b0;
    g_out      = 1'b0;
    sub        = 1'b0;
    din_out    = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      T1: begin
        case (w_op)
          OP_MV: begin
            w_rout_en  = 1'b1;
            w_rout_sel = w_y;
            w_rin_en   = 1'b1;
            done       = 1'b1;
          end
          OP_MVI: begin
            din_out  = 1'b1;
            w_rin_en = 1'b1;
            done     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_rout_en = 1'b1;
            a_in      = 1'b1;
          end
          default: begin
            done    = 1'b1;
            illegal = 1'b1;
          end
        endcase
      end
      T2: begin
        w_rout_en  = 1'b1;
        w_rout_sel = w_y;
        g_in       = 1'b1;
        sub        = (w_op == OP_SUB);
      end
      T3: begin
        g_out    = 1'b1;
        w_rin_en = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != T0);

  // Register write enable always targets Rx
  dec_onehot #(.SEL_W(SEL_W), .NREG(NREG)) u_dec_rin (
    .en     (w_rin_en),
    .sel    (w_x),
    .onehot (r_in)
  );

  // Register bus-drive select targets Rx or Ry depending on the step
  dec_onehot #(.SEL_W(SEL_W), .NREG(NREG)) u_dec_rout (
    .en     (w_rout_en),
    .sel    (w_rout_sel),
    .onehot (r_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_ctrl_fsm
// Description : Self-checking bench for cpu_ctrl_fsm. A behavioural model
//               pushes the expected per-cycle control vectors for each
//               instruction into a queue; they are popped as the sequencer
//               steps through its timing states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] din;
  logic [7:0]  r_in;
  logic [7:0]  r_out;
  logic        a_in, g_in, g_out, sub, din_out, done, busy, illegal;

  typedef struct packed {
    logic [7:0] r_in;
    logic [7:0] r_out;
    logic       a_in;
    logic       g_in;
    logic       g_out;
    logic       sub;
    logic       din_out;
    logic       done;
    logic       busy;
    logic       illegal;
  } obs_t;

  obs_t obs;
  obs_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  cpu_ctrl_fsm #(.DATA_W(16), .NREG(8), .SEL_W(3)) dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .din     (din),
    .r_in    (r_in),
    .r_out   (r_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .sub     (sub),
    .din_out (din_out),
    .done    (done),
    .busy    (busy),
    .illegal (illegal)
  );

  always #5 clock = ~clock;

  always_comb obs = {r_in, r_out, a_in, g_in, g_out, sub, din_out, done, busy, illegal};

  // Bus-source exclusivity and one-hot enables, every cycle
  always @(negedge clock) begin
    if (!$isunknown(obs)) begin
      checks++;
      if ((int'(|r_out) + int'(g_out) + int'(din_out)) > 1 ||
          !$onehot0(r_in) || !$onehot0(r_out) || (sub && !g_in)) begin
        errors++;
        $display("FAIL invariant: got %h (r_out=%h g_out=%b din_out=%b r_in=%h sub=%b)",
                 obs, r_out, g_out, din_out, r_in, sub);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  // Expected cycle-by-cycle controls for one instruction, T1 onwards
  task automatic model_push(input logic [15:0] w);
    logic [2:0] op, x, y;
    obs_t e;
    op = w[15:13];
    x  = w[12:10];
    y  = w[9:7];
    e = '0; e.busy = 1'b1;
    case (op)
      3'd0: begin e.r_out = 8'd1 << y; e.r_in = 8'd1 << x; e.done = 1'b1; sbq.push_back(e); end
      3'd1: begin e.din_out = 1'b1; e.r_in = 8'd1 << x; e.done = 1'b1; sbq.push_back(e); end
      3'd2, 3'd3: begin
        e.r_out = 8'd1 << x; e.a_in = 1'b1; sbq.push_back(e);
        e = '0; e.busy = 1'b1;
        e.r_out = 8'd1 << y; e.g_in = 1'b1; e.sub = (op == 3'd3); sbq.push_back(e);
        e = '0; e.busy = 1'b1;
        e.g_out = 1'b1; e.r_in = 8'd1 << x; e.done = 1'b1; sbq.push_back(e);
      end
      default: begin e.done = 1'b1; e.illegal = 1'b1; sbq.push_back(e); end
    endcase
  endtask

  // Issue one instruction from T0 and follow it back to T0
  task automatic exec(input logic [15:0] w, input logic [15:0] imm, input bit jitter);
    obs_t e;
    model_push(w);
    run = 1'b1;
    din = w;
    @(posedge clock); #1;
    din = imm;
    while (sbq.size() > 0) begin
      run = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
      e = sbq.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL exec_%h: got %h want %h", w, obs, e);
      end
      if (sbq.size() > 0) begin @(posedge clock); #1; end
    end
    @(posedge clock); #1;
    run = 1'b0;
    checks++;
    if (obs !== obs_t'(0)) begin
      errors++;
      $display("FAIL idle_after_%h: got %h want %h", w, obs, obs_t'(0));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run   = 1'b1;
    din   = 16'h1E80;
    repeat (2) begin
      @(posedge clock); #1;
      checks++;
      if (obs !== obs_t'(0)) begin
        errors++;
        $display("FAIL reset_outputs: got %h want %h", obs, obs_t'(0));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_mv();
    exec(16'h1E80, 16'h0000, 1'b0);  // mv R7,R5
    exec(16'h1B00, 16'h0000, 1'b0);  // mv R6,R6
  endtask

  task automatic test_mvi();
    exec(16'h2800, 16'h00AB, 1'b0);  // mvi R2,#0xAB
  endtask

  task automatic test_add();
    exec(16'h4500, 16'h0000, 1'b0);  // add R1,R2
  endtask

  task automatic test_sub();
    exec(16'h6C00, 16'h0000, 1'b0);  // sub R3,R0
  endtask

  task automatic test_illegal();
    exec(16'hE000, 16'h0000, 1'b0);
    exec(16'h8D80, 16'h0000, 1'b0);
  endtask

  task automatic test_run_ignored();
    exec(16'h4500, 16'hFFFF, 1'b1);
    exec(16'h7F80, 16'hFFFF, 1'b1);  // sub R7,R7
  endtask

  task automatic test_back_to_back();
    exec(16'h6C00, 16'h0000, 1'b0);
    exec(16'h1E80, 16'h0000, 1'b0);
    exec(16'h2800, 16'h1234, 1'b0);
    exec(16'h4500, 16'h0000, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 12; i++) begin
      w = 16'($urandom);
      exec(w, 16'($urandom), 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    model_push(16'h4500);
    run = 1'b1;
    din = 16'h4500;
    @(posedge clock); #1;
    run = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_mid_t1: got %h want %h", obs, e);
    end
    @(posedge clock); #1;
    e = sbq.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_mid_t2: got %h want %h", obs, e);
    end
    sbq.delete();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_done: got %b want 0", done);
    end
    checks++;
    if (obs !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_mid_idle: got %h want %h", obs, obs_t'(0));
    end
    @(posedge clock); #1;
    checks++;
    if (obs !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_mid_stay: got %h want %h", obs, obs_t'(0));
    end
    exec(16'h6C00, 16'h0000, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    din   = '0;
    test_reset();
    test_mv();
    test_mvi();
    test_add();
    test_sub();
    test_illegal();
    test_run_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
